// File: rtl/crt_pkg.sv
// rtl/crt_pkg.sv - CRT memory arbiter widths and FSM encoding (CRT_ARB_PREFETCH_EN adds prefetch states)
package crt_pkg;

    localparam int ADDR_W = 20;
    localparam int PAGE_W = 7;
    localparam int VOFS_W = 13;
    localparam int DATA_W = 8;

`ifdef CRT_ARB_PREFETCH_EN
    typedef enum logic [3:0] {
        ST_IDLE, ST_VRD1, ST_VRD2, ST_CRD1, ST_CRD2, ST_CWR1, ST_CWR2, ST_PRD1, ST_PRD2
    } arb_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_VRD1, ST_VRD2, ST_CRD1, ST_CRD2, ST_CWR1, ST_CWR2
    } arb_state_t;
`endif

endpackage

// File: rtl/crt_strobe_sync.sv
// rtl/crt_strobe_sync.sv - two-flop synchronizer with rising-edge detect for the CPU strobe
module crt_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic strobe_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    // shift the raw strobe through the synchronizer and keep one delayed copy for edge detect
    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // synchronizer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign strobe_o = sync2_q & ~prev_q;

endmodule

// File: rtl/crt_mem_arb.sv
// rtl/crt_mem_arb.sv - video/CPU SRAM arbiter; CRT_ARB_PREFETCH_EN enables video byte prefetch
module crt_mem_arb
    import crt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_da,
    input  logic [DATA_W-1:0] cpu_dbo,
    input  logic              cpu_ds,
    input  logic              cpu_wr,
    input  logic              mem_hold,
    input  logic [PAGE_W-1:0] page,
    input  logic              vid_req,
    input  logic [VOFS_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_ack,
    output logic [DATA_W-1:0] cpu_dbi,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    arb_state_t        state_q, state_d;
    logic              cpu_strobe;
    logic              cpu_pend_q, cpu_pend_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic              cpu_wr_q, cpu_wr_d;
    logic              last_vid_q, last_vid_d;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [DATA_W-1:0] sram_dq_o_q, sram_dq_o_d;
    logic              sram_dq_oe_q, sram_dq_oe_d;
    logic              sram_oe_n_q, sram_oe_n_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_ack_q, vid_ack_d;
    logic [DATA_W-1:0] cpu_dbi_q, cpu_dbi_d;
    logic              vid_go, cpu_go, cpu_cycle;

`ifdef CRT_ARB_PREFETCH_EN
    logic              pf_arm_q, pf_arm_d;
    logic [VOFS_W-1:0] pf_ofs_q, pf_ofs_d;
    logic [DATA_W-1:0] pf_data_q, pf_data_d;
    logic [ADDR_W-1:0] pf_tag_q, pf_tag_d;
    logic              pf_valid_q, pf_valid_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic              pf_hit;
    assign pf_hit = pf_valid_q && (pf_tag_q == {page, vid_addr});
`endif

    crt_strobe_sync u_ds_sync (
        .clk      (clk),
        .reset    (reset),
        .async_i  (cpu_ds),
        .strobe_o (cpu_strobe)
    );

    // the request is still high in the ack cycle, so mask it there to avoid a duplicate read
    assign vid_go    = vid_req & ~vid_ack_q;
    assign cpu_go    = cpu_pend_q & mem_hold;
    assign cpu_cycle = (state_q == ST_CRD1) || (state_q == ST_CRD2) ||
                       (state_q == ST_CWR1) || (state_q == ST_CWR2);

    // CPU request capture: latch on a held strobe, drop while busy, cancel if hold is lost early
    always_comb begin
        cpu_pend_d  = cpu_pend_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        cpu_wr_d    = cpu_wr_q;
        if (state_q == ST_CRD2 || state_q == ST_CWR2) begin
            cpu_pend_d = 1'b0;
        end else if (cpu_pend_q && !mem_hold && !cpu_cycle) begin
            cpu_pend_d = 1'b0;
        end else if (cpu_strobe && mem_hold && !cpu_pend_q) begin
            cpu_pend_d  = 1'b1;
            cpu_addr_d  = cpu_da;
            cpu_wdata_d = cpu_dbo;
            cpu_wr_d    = cpu_wr;
        end
    end

    // arbitration, read capture and registered SRAM controls derived from the next state
    always_comb begin
        state_d      = state_q;
        last_vid_d   = last_vid_q;
        vid_ack_d    = 1'b0;
        vid_data_d   = vid_data_q;
        cpu_dbi_d    = cpu_dbi_q;
        sram_a_d     = sram_a_q;
        sram_dq_o_d  = sram_dq_o_q;
        sram_dq_oe_d = 1'b0;
        sram_oe_n_d  = 1'b1;
        sram_we_n_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
`ifdef CRT_ARB_PREFETCH_EN
                if (vid_go && pf_hit) begin
                    vid_ack_d  = 1'b1;
                    vid_data_d = pf_data_q;
                end else
`endif
                if (vid_go && (!cpu_go || !last_vid_q)) begin
                    state_d  = ST_VRD1;
                    sram_a_d = {page, vid_addr};
                end else if (cpu_go) begin
                    state_d  = cpu_wr_q ? ST_CWR1 : ST_CRD1;
                    sram_a_d = cpu_addr_q;
                end
`ifdef CRT_ARB_PREFETCH_EN
                else if (pf_arm_q && !cpu_pend_q && !vid_go) begin
                    state_d  = ST_PRD1;
                    sram_a_d = {page, pf_ofs_q};
                end
`endif
            end
            ST_VRD1: state_d = ST_VRD2;
            ST_VRD2: begin
                state_d    = ST_IDLE;
                vid_data_d = sram_dq_i;
                vid_ack_d  = 1'b1;
                last_vid_d = 1'b1;
            end
            ST_CRD1: state_d = ST_CRD2;
            ST_CRD2: begin
                state_d    = ST_IDLE;
                cpu_dbi_d  = sram_dq_i;
                last_vid_d = 1'b0;
            end
            ST_CWR1: state_d = ST_CWR2;
            ST_CWR2: begin
                state_d    = ST_IDLE;
                last_vid_d = 1'b0;
            end
`ifdef CRT_ARB_PREFETCH_EN
            ST_PRD1: state_d = ST_PRD2;
            ST_PRD2: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_VRD1, ST_VRD2, ST_CRD1, ST_CRD2: sram_oe_n_d = 1'b0;
            ST_CWR1: begin
                sram_dq_oe_d = 1'b1;
                sram_dq_o_d  = cpu_wdata_q;
            end
            ST_CWR2: begin
                sram_dq_oe_d = 1'b1;
                sram_dq_o_d  = cpu_wdata_q;
                sram_we_n_d  = 1'b0;
            end
`ifdef CRT_ARB_PREFETCH_EN
            ST_PRD1, ST_PRD2: sram_oe_n_d = 1'b0;
`endif
            default: ;
        endcase
    end

`ifdef CRT_ARB_PREFETCH_EN
    // prefetch bookkeeping: arm after each video fetch, fill on PRD2, invalidate on writes/page change
    always_comb begin
        pf_arm_d   = pf_arm_q;
        pf_ofs_d   = pf_ofs_q;
        pf_data_d  = pf_data_q;
        pf_tag_d   = pf_tag_q;
        pf_valid_d = pf_valid_q;
        page_d     = page;
        if (state_q == ST_VRD2) begin
            pf_arm_d = 1'b1;
            pf_ofs_d = sram_a_q[VOFS_W-1:0] + VOFS_W'(1);
        end else if (state_q == ST_IDLE && vid_go && pf_hit) begin
            pf_arm_d = 1'b1;
            pf_ofs_d = vid_addr + VOFS_W'(1);
        end else if (state_q == ST_IDLE && state_d != ST_IDLE) begin
            pf_arm_d = 1'b0;
        end
        if (state_q == ST_PRD2) begin
            pf_data_d  = sram_dq_i;
            pf_tag_d   = sram_a_q;
            pf_valid_d = (sram_a_q[ADDR_W-1:VOFS_W] == page);
        end
        if (page != page_q || state_q == ST_CWR1 || state_q == ST_CWR2 ||
            (cpu_strobe && mem_hold && cpu_wr)) begin
            pf_valid_d = 1'b0;
        end
    end

    // prefetch state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_arm_q   <= 1'b0;
            pf_ofs_q   <= '0;
            pf_data_q  <= '0;
            pf_tag_q   <= '0;
            pf_valid_q <= 1'b0;
            page_q     <= '0;
        end else begin
            pf_arm_q   <= pf_arm_d;
            pf_ofs_q   <= pf_ofs_d;
            pf_data_q  <= pf_data_d;
            pf_tag_q   <= pf_tag_d;
            pf_valid_q <= pf_valid_d;
            page_q     <= page_d;
        end
    end
`endif

    // arbiter state register; reset aborts any SRAM cycle in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cpu_pend_q   <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            cpu_wr_q     <= 1'b0;
            last_vid_q   <= 1'b0;
            sram_a_q     <= '0;
            sram_dq_o_q  <= '0;
            sram_dq_oe_q <= 1'b0;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            vid_data_q   <= '0;
            vid_ack_q    <= 1'b0;
            cpu_dbi_q    <= '0;
        end else begin
            state_q      <= state_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_wdata_q  <= cpu_wdata_d;
            cpu_wr_q     <= cpu_wr_d;
            last_vid_q   <= last_vid_d;
            sram_a_q     <= sram_a_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_dq_oe_q <= sram_dq_oe_d;
            sram_oe_n_q  <= sram_oe_n_d;
            sram_we_n_q  <= sram_we_n_d;
            vid_data_q   <= vid_data_d;
            vid_ack_q    <= vid_ack_d;
            cpu_dbi_q    <= cpu_dbi_d;
        end
    end

    assign vid_data   = vid_data_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_dbi    = cpu_dbi_q;
    assign sram_a     = sram_a_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_we_n  = sram_we_n_q;

endmodule

// File: tb/tb_crt_mem_arb.sv
// tb/tb_crt_mem_arb.sv - directed self-checking bench for crt_mem_arb (CRT_ARB_PREFETCH_EN adds prefetch vectors)
module tb_crt_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] cpu_da;
    logic [7:0]  cpu_dbo;
    logic        cpu_ds;
    logic        cpu_wr;
    logic        mem_hold;
    logic [6:0]  page;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_ack;
    logic [7:0]  cpu_dbi;
    logic [19:0] sram_a;
    logic [7:0]  sram_dq_i;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_oe_n;
    logic        sram_we_n;

    int total = 0;
    int bad   = 0;

    crt_mem_arb dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_da     (cpu_da),
        .cpu_dbo    (cpu_dbo),
        .cpu_ds     (cpu_ds),
        .cpu_wr     (cpu_wr),
        .mem_hold   (mem_hold),
        .page       (page),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_ack    (vid_ack),
        .cpu_dbi    (cpu_dbi),
        .sram_a     (sram_a),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // pulse cpu_ds for three cycles and tally SRAM activity over ncyc cycles
    task automatic ds_watch(input int ncyc, output int we_lo, output int oe_lo, output int dqoe,
                            output logic [19:0] wa, output logic [7:0] wd);
        we_lo = 0; oe_lo = 0; dqoe = 0; wa = '0; wd = '0;
        cpu_ds = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 3) cpu_ds = 1'b0;
            if (!sram_we_n) begin
                we_lo++;
                wa = sram_a;
                wd = sram_dq_o;
            end
            if (!sram_oe_n) oe_lo++;
            if (sram_dq_oe) dqoe++;
        end
    endtask

    // raise vid_req and count cycles to the ack; lat=99 when no ack arrives
    task automatic vid_read(output int lat, output logic [19:0] a);
        lat = 99; a = '0;
        vid_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!sram_oe_n) a = sram_a;
            if (vid_ack) begin
                lat = i;
                break;
            end
        end
        vid_req = 1'b0;
    endtask

    int          we_lo, oe_lo, dqoe, lat, acks, found, cnt;
    logic [19:0] wa, va;
    logic [7:0]  wd;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_da = '0; cpu_dbo = '0; cpu_ds = 1'b0; cpu_wr = 1'b0;
        mem_hold = 1'b0; page = '0; vid_req = 1'b0; vid_addr = '0; sram_dq_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_a", sram_a, 0);
        chk("rst_dq_o", sram_dq_o, 0);
        chk("rst_vid_ack", vid_ack, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_dbi", cpu_dbi, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // CPU write
        mem_hold = 1'b1; cpu_wr = 1'b1; cpu_da = 20'h12345; cpu_dbo = 8'hA5;
        ds_watch(15, we_lo, oe_lo, dqoe, wa, wd);
        chk("wr_we_lo_cycles", we_lo, 1);
        chk("wr_dq_oe_cycles", dqoe, 2);
        chk("wr_oe_lo_cycles", oe_lo, 0);
        chk("wr_addr", wa, 20'h12345);
        chk("wr_data", wd, 8'hA5);
        chk("wr_dbi_untouched", cpu_dbi, 0);

        // video read at the top of page 5
        page = 7'h05; vid_addr = 13'h1FFF; sram_dq_i = 8'h3C;
        vid_read(lat, va);
        chk("vid_latency", lat, 3);
        chk("vid_addr", va, 20'h0BFFF);
        chk("vid_data", vid_data, 8'h3C);
        @(negedge clk);
        chk("vid_ack_one_cycle", vid_ack, 0);
        repeat (3) @(negedge clk);

        // CPU read competing with continuous video requests
        cpu_wr = 1'b0; cpu_da = 20'h00777; sram_dq_i = 8'h77; vid_addr = 13'h0100;
        vid_req = 1'b1;
        repeat (2) @(negedge clk);
        cpu_ds = 1'b1; acks = 0; found = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) cpu_ds = 1'b0;
            if (vid_ack) acks++;
            if (found == 0 && cpu_dbi == 8'h77) found = i;
        end
        vid_req = 1'b0;
        chk("cpu_rd_found", (found != 0) ? 1 : 0, 1);
        chk("cpu_rd_in_time", (found != 0 && found <= 11) ? 1 : 0, 1);
        chk("vid_acks_alternate", (acks >= 2) ? 1 : 0, 1);
        repeat (6) @(negedge clk);

        // strobe without memory hold is ignored, and leaves nothing pending
        mem_hold = 1'b0; cpu_wr = 1'b1; cpu_dbo = 8'h5A; sram_dq_i = 8'h99;
        ds_watch(12, we_lo, oe_lo, dqoe, wa, wd);
        chk("nohold_we", we_lo, 0);
        chk("nohold_oe", oe_lo, 0);
        chk("nohold_dqoe", dqoe, 0);
        mem_hold = 1'b1; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!sram_we_n || !sram_oe_n || sram_dq_oe) cnt++;
        end
        chk("nohold_no_late_cycle", cnt, 0);
        chk("nohold_dbi_kept", cpu_dbi, 8'h77);

        // reset in CWR2 aborts the write immediately
        cpu_wr = 1'b1; cpu_da = 20'h00ABC; cpu_dbo = 8'h3E; cpu_ds = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) cpu_ds = 1'b0;
            if (!sram_we_n) break;
        end
        cpu_ds = 1'b0;
        chk("cwr2_reached", sram_we_n, 0);
        reset = 1'b1;
        #1;
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_dq_oe", sram_dq_oe, 0);
        chk("abort_oe_n", sram_oe_n, 1);
        chk("abort_a", sram_a, 0);
        chk("abort_dq_o", sram_dq_o, 0);
        @(negedge clk);
        reset = 1'b0; acks = 0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vid_ack) acks++;
            if (!sram_we_n) cnt++;
        end
        chk("post_rst_no_ack", acks, 0);
        chk("post_rst_no_write", cnt, 0);

`ifdef CRT_ARB_PREFETCH_EN
        // prefetch hit after wrap, then invalidated by a CPU write
        page = 7'h02; sram_dq_i = 8'h11;
        repeat (2) @(negedge clk);
        vid_addr = 13'h1FFF;
        vid_read(lat, va);
        chk("pf_miss_lat", lat, 3);
        repeat (6) @(negedge clk);
        vid_addr = 13'h0000;
        vid_read(lat, va);
        chk("pf_hit_lat", lat, 1);
        chk("pf_hit_no_sram", va, 0);
        chk("pf_hit_data", vid_data, 8'h11);
        repeat (6) @(negedge clk);
        vid_addr = 13'h1FFF;
        vid_read(lat, va);
        chk("pf_refill_lat", lat, 3);
        repeat (6) @(negedge clk);
        mem_hold = 1'b1; cpu_wr = 1'b1; cpu_da = 20'h00010; cpu_dbo = 8'h44;
        ds_watch(12, we_lo, oe_lo, dqoe, wa, wd);
        chk("pf_wr_done", we_lo, 1);
        vid_addr = 13'h0000;
        vid_read(lat, va);
        chk("pf_inval_lat", lat, 3);
        chk("pf_inval_addr", va, 20'h04000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
